// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between the multicycle CPU and a DMA/debug loader.
// CPU has priority; a wait counter forces DMA service, and a burst counter limits how long DMA stalls the CPU.
module mem_port_arbiter #(
  parameter int unsigned AW       = 12,
  parameter int unsigned DW       = 16,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned BURST    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam int unsigned BW = $clog2(BURST + 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
  localparam logic [BW-1:0] BURST_MAX = BW'(BURST);

  typedef enum logic {S_CPU, S_DMA} state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic [BW-1:0] burst_cnt;
  logic          cpu_gnt;

  // Grants are gated by rst so that no access reaches memory while reset is held.
  always_comb begin
    dma_gnt = 1'b0;
    cpu_gnt = 1'b0;
    if (!rst) begin
      if (state == S_CPU)
        dma_gnt = dma_req && (!cpu_req || (wait_cnt == WAIT_MAX));
      else
        dma_gnt = dma_req && (!cpu_req || (burst_cnt < BURST_MAX));
      cpu_gnt = cpu_req && !dma_gnt;
    end
  end

  always_comb begin
    if (dma_gnt) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_we;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_gnt && cpu_we;
    end
  end

  assign cpu_stall = cpu_req && !cpu_gnt;
  assign cpu_rdata = mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_CPU;
      wait_cnt   <= '0;
      burst_cnt  <= '0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_rvalid <= dma_gnt && !dma_we;
      if (dma_gnt && !dma_we)
        dma_rdata <= mem_rdata;

      if (dma_gnt) begin
        state    <= S_DMA;
        wait_cnt <= '0;
        if (state == S_CPU)
          burst_cnt <= BW'(1);
        else if (burst_cnt != BURST_MAX)
          burst_cnt <= burst_cnt + 1'b1;
      end else begin
        // Leaving (or staying out of) a burst always restarts both counters,
        // except that a CPU-granted cycle with DMA pending ages the wait count.
        state     <= S_CPU;
        burst_cnt <= '0;
        if (state == S_CPU && dma_req && cpu_req && wait_cnt != WAIT_MAX)
          wait_cnt <= wait_cnt + 1'b1;
        else if (state == S_CPU && dma_req && cpu_req)
          wait_cnt <= WAIT_MAX;
        else
          wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a cycle model predicts each grant and the DMA read returns.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;
  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned BURST = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata;
  logic [DW-1:0] cpu_rdata, dma_rdata;
  logic          cpu_stall, dma_gnt, dma_rvalid;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .BURST(BURST)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic          dma;
    logic          stall;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] rd_q[$];
  int            n_chk = 0;
  int            n_err = 0;

  // reference model state
  bit            m_dma_mode;
  int            m_wait, m_burst;
  logic          last_gnt, last_stall;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                        input logic dr, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
  endtask

  task automatic model_reset();
    m_dma_mode = 1'b0;
    m_wait     = 0;
    m_burst    = 0;
    rd_q.delete();
    exp_q.delete();
  endtask

  // One clock cycle: predict at the falling edge, compare, then advance the model at the rising edge.
  task automatic cycle();
    exp_t          e, got;
    logic          wr_en;
    logic [AW-1:0] wr_a;
    logic [DW-1:0] wr_d;
    @(negedge clk);
    if (rd_q.size() > 0) begin
      check("rvalid", 32'(dma_rvalid), 32'd1);
      check("rdata", 32'(dma_rdata), 32'(rd_q.pop_front()));
    end else begin
      check("rvalid", 32'(dma_rvalid), 32'd0);
    end

    if (m_dma_mode) e.dma = dma_req && (!cpu_req || m_burst < int'(BURST));
    else            e.dma = dma_req && (!cpu_req || m_wait == int'(MAX_WAIT));
    e.stall = cpu_req && e.dma;
    e.we    = e.dma ? dma_we : (cpu_req && cpu_we);
    e.addr  = e.dma ? dma_addr : cpu_addr;
    e.wdata = e.dma ? dma_wdata : cpu_wdata;
    exp_q.push_back(e);
    if (e.dma && !dma_we) rd_q.push_back(mem[dma_addr]);

    got = exp_q.pop_front();
    check("dma_gnt", 32'(dma_gnt), 32'(got.dma));
    check("cpu_stall", 32'(cpu_stall), 32'(got.stall));
    check("mem_we", 32'(mem_we), 32'(got.we));
    check("mem_addr", 32'(mem_addr), 32'(got.addr));
    check("mem_wdata", 32'(mem_wdata), 32'(got.wdata));
    check("cpu_rdata", 32'(cpu_rdata), 32'(mem[got.addr]));
    last_gnt   = dma_gnt;
    last_stall = cpu_stall;
    wr_en = mem_we; wr_a = mem_addr; wr_d = mem_wdata;

    @(posedge clk);
    if (wr_en) mem[wr_a] = wr_d;
    if (e.dma) begin
      m_burst    = m_dma_mode ? ((m_burst + 1 > int'(BURST)) ? int'(BURST) : m_burst + 1) : 1;
      m_dma_mode = 1'b1;
      m_wait     = 0;
    end else begin
      if (!m_dma_mode && dma_req && cpu_req)
        m_wait = (m_wait + 1 > int'(MAX_WAIT)) ? int'(MAX_WAIT) : m_wait + 1;
      else
        m_wait = 0;
      m_dma_mode = 1'b0;
      m_burst    = 0;
    end
    #1;
  endtask

  initial begin
    logic [8:0] gnt_pat, stall_pat;
    int         cnt;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic          rw;

    for (int unsigned i = 0; i < (1 << AW); i++) mem[i] = DW'(i) ^ 16'h5A5A;
    mem[12'h020] = 16'hBEEF;
    set_in(0, 0, '0, '0, 0, 0, '0, '0);
    rst = 1'b1;
    model_reset();
    #2;
    check("rst_gnt", 32'(dma_gnt), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_rvalid", 32'(dma_rvalid), 32'd0);
    check("rst_rdata", 32'(dma_rdata), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // CPU-only write then read back
    set_in(1, 1, 12'h010, 16'h1234, 0, 0, '0, '0);
    cycle();
    set_in(1, 0, 12'h010, '0, 0, 0, '0, '0);
    cycle();
    set_in(0, 0, '0, '0, 0, 0, '0, '0);
    cycle();

    // DMA read with CPU idle
    set_in(0, 0, '0, '0, 1, 0, 12'h020, '0);
    cycle();
    check("t2_gnt", 32'(last_gnt), 32'd1);
    check("t2_rvalid", 32'(dma_rvalid), 32'd1);
    check("t2_rdata", 32'(dma_rdata), 32'hBEEF);
    set_in(0, 0, '0, '0, 0, 0, '0, '0);
    cycle();
    check("t2_rvalid_drop", 32'(dma_rvalid), 32'd0);

    // Contention: both held from cycle 0
    set_in(1, 0, 12'h100, '0, 1, 0, 12'h200, '0);
    for (int i = 0; i < 9; i++) begin
      cycle();
      gnt_pat[i]   = last_gnt;
      stall_pat[i] = last_stall;
    end
    check("t3_gnt_pattern", 32'(gnt_pat), 32'h0F0);
    check("t3_stall_pattern", 32'(stall_pat), 32'h0F0);
    for (int i = 0; i < 12; i++) cycle();
    set_in(0, 0, '0, '0, 0, 0, '0, '0);
    cycle();

    // Long DMA write burst with CPU idle, then CPU arrives
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      set_in(0, 0, '0, '0, 1, 1, 12'h300 + 12'(i), 16'hA000 + 16'(i));
      cycle();
      cnt += int'(last_gnt);
    end
    check("t4_burst_len", 32'(cnt), 32'd10);
    set_in(1, 0, 12'h300, '0, 1, 1, 12'h30A, 16'hA00A);
    cycle();
    check("t4_cpu_wins", 32'({last_gnt, last_stall}), 32'd0);
    set_in(0, 0, '0, '0, 0, 0, '0, '0);
    cycle();

    // DMA drops after two burst grants while CPU waits
    set_in(0, 0, '0, '0, 1, 0, 12'h305, '0);
    cycle();
    set_in(1, 0, 12'h040, '0, 1, 0, 12'h306, '0);
    cycle();
    check("t5_second_burst", 32'({last_gnt, last_stall}), 32'd3);
    set_in(1, 0, 12'h040, '0, 0, 0, '0, '0);
    cycle();
    check("t5_cpu_next", 32'({last_gnt, last_stall}), 32'd0);
    set_in(1, 0, 12'h041, '0, 1, 0, 12'h307, '0);
    cycle();
    check("t5_wait_restart", 32'({last_gnt, last_stall}), 32'd0);
    set_in(0, 0, '0, '0, 0, 0, '0, '0);
    cycle();

    // Reset mid-burst during a DMA write that follows a read
    set_in(0, 0, '0, '0, 1, 0, 12'h020, '0);
    cycle();
    set_in(0, 0, '0, '0, 1, 1, 12'h021, 16'hDEAD);
    rst = 1'b1;
    #1;
    check("t6_we", 32'(mem_we), 32'd0);
    check("t6_gnt", 32'(dma_gnt), 32'd0);
    check("t6_rvalid", 32'(dma_rvalid), 32'd0);
    model_reset();
    @(posedge clk); #1;
    set_in(1, 0, 12'h050, '0, 1, 0, 12'h060, '0);
    rst = 1'b0;
    cycle();
    check("t6_cpu_first", 32'({last_gnt, last_stall}), 32'd0);

    // Randomised traffic; DMA holds its request until granted
    rw = 1'b0; ra = '0; rd = '0;
    for (int i = 0; i < 300; i++) begin
      if (!dma_req || last_gnt) begin
        rw = 1'($urandom_range(0, 1));
        ra = AW'($urandom_range(0, 15));
        rd = DW'($urandom);
        dma_req = ($urandom_range(0, 3) != 0);
      end
      dma_we = rw; dma_addr = ra; dma_wdata = rd;
      if (!cpu_stall) begin
        cpu_req   = ($urandom_range(0, 3) != 0);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = AW'($urandom_range(0, 15));
        cpu_wdata = DW'($urandom);
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
